rc4_xor_stage: RTL and testbench
================================

Name: rc4_xor_stage

Overview:
Downstream consumer of the RC4 keystream generator. It buffers incoming keystream bytes in a small FIFO and XORs each one with one plaintext or ciphertext byte from a data stream. It emits the result on a valid/ready output and counts bytes against a programmed message length. The same block serves encryption and decryption; it sits between the keystream generator and the byte-stream sink.

Parameters:
KS_DEPTH, 8, keystream FIFO depth in bytes; must be a power of 2, at least 2.
KS_AW, 3, FIFO pointer width, equal to log2(KS_DEPTH).
LEN_W, 16, width of the message-length field and byte counter.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a message; honoured only in IDLE
msg_len  input  LEN_W  message length in bytes; sampled on the accepted start
ks_data  input  8  keystream byte
ks_valid  input  1  ks_data valid
ks_ready  output  1  FIFO can accept a keystream byte
in_data  input  8  plaintext or ciphertext byte
in_valid  input  1  in_data valid
in_ready  output  1  stage accepts in_data this cycle
out_data  output  8  in_data XOR keystream byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts out_data
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when the last byte of a message is taken by the sink

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; FIFO emptied (rd_ptr=wr_ptr=0, count=0); byte counter=0.
  - out_data=0, out_valid=0, done=0, busy=0.
  - ks_ready=1 in the cycle after reset releases; in_ready=0.
  - A reset mid-message discards the FIFO contents and any pending output.
- Keystream FIFO:
  - ks_ready = (count != KS_DEPTH); it depends on the registered count only, so a same-cycle pop does not raise it.
  - Push on ks_valid && ks_ready.
  - Pop on an input handshake.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo KS_DEPTH.
  - The FIFO is filled in every state, including IDLE, so keystream continuity is preserved across messages.
- Output register (single stage):
  - out_slot_free = ~out_valid || out_ready.
  - On an input handshake: out_data <= in_data ^ fifo_head, and out_valid <= 1.
  - If out_valid && out_ready with no new handshake: out_valid <= 0, and out_data holds its value.
- FSM:
  - IDLE: in_ready=0.
    - start && msg_len!=0 -> latch length, counter=0, go to RUN.
    - start && msg_len==0 -> done=1 for one cycle, stay in IDLE.
  - RUN: in_ready = (count!=0) && out_slot_free && (counter < len).
    - Input handshake = in_valid && in_ready; it increments the counter.
    - The handshake that brings the counter to len -> go to DRAIN.
  - DRAIN: in_ready=0. When out_valid && out_ready: done=1 for one cycle and go to IDLE.
- Latency: one cycle from input handshake to out_valid. Full throughput of one byte per clock when the FIFO is non-empty and the sink is ready.
- start in RUN or DRAIN is ignored; msg_len is not resampled.
- in_valid with an empty FIFO stalls: in_ready=0, no byte is lost.
- The counter compares at LEN_W bits and never wraps within a message.

Test Plan:
1. Pre-load keystream EB 9F 77 81, start with msg_len=4, in_data 50 6C 61 69, out_ready=1 -> out_data BB F3 16 E8 on consecutive cycles, each one cycle after its handshake; done pulses when E8 is accepted; FIFO empty afterwards.
2. Same traffic with out_ready toggling 1,0,0,1,... -> no byte dropped or duplicated; out_data stable while out_valid && !out_ready; in_ready=0 whenever the output slot is full.
3. Push 9 keystream bytes with KS_DEPTH=8 and no consumption -> ks_ready=0 after 8 pushes, 9th byte held by the source; one pop then re-asserts ks_ready the next cycle.
4. start with msg_len=0 -> done pulses one cycle later, busy stays 0, FIFO untouched.
5. Assert rst_n=0 mid-message after 2 of 6 bytes -> next cycle out_valid=0, busy=0, count=0, ks_ready=1; a new message then uses fresh keystream from the FIFO head.
6. Pulse start while busy, with a different msg_len -> ignored; the original message completes with the original byte count and exactly one done pulse.

Source files
------------

// File: rtl/rc4_xor_stage.sv
// -----------------------------------------------------------------------------
// rc4_xor_stage
//
// Purpose:
//   Sits between the RC4 keystream generator and the byte-stream sink. Incoming
//   keystream bytes are buffered in a small FIFO. Each accepted data byte is
//   XORed with the byte at the FIFO head. The result leaves through a
//   single-stage valid/ready output register. Because XOR is its own inverse,
//   the same path both encrypts and decrypts.
//
//   A message starts with a start pulse that carries msg_len. The stage then
//   accepts exactly msg_len data bytes. After the last byte leaves through the
//   output register, done pulses for one cycle.
//
//   The FIFO keeps filling in every state, IDLE included. Keystream that is not
//   used by one message is therefore the first keystream used by the next one.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   start, msg_len      message start pulse and byte count (sampled in IDLE)
//   ks_data/valid/ready keystream input handshake (FIFO push side)
//   in_data/valid/ready plaintext/ciphertext input handshake
//   out_data/valid/ready XOR result, registered, valid/ready handshake
//   busy                high while a message is in RUN or DRAIN
//   done                one-cycle pulse after the last byte is taken by the sink
//
// KS_AW must equal log2(KS_DEPTH), and KS_DEPTH must be a power of two, so the
// FIFO pointers can wrap by natural overflow.
// -----------------------------------------------------------------------------
module rc4_xor_stage #(
  parameter int KS_DEPTH = 8,
  parameter int KS_AW    = 3,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [7:0]       ks_data,
  input  logic             ks_valid,
  output logic             ks_ready,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [KS_AW:0]   FIFO_FULL = (KS_AW+1)'(KS_DEPTH);
  localparam logic [KS_AW:0]   CNT_ONE   = (KS_AW+1)'(1'b1);
  localparam logic [KS_AW:0]   CNT_ZERO  = (KS_AW+1)'(1'b0);
  localparam logic [KS_AW-1:0] PTR_ONE   = KS_AW'(1'b1);
  localparam logic [KS_AW-1:0] PTR_ZERO  = KS_AW'(1'b0);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1'b1);
  localparam logic [LEN_W-1:0] LEN_ZERO  = LEN_W'(1'b0);

  // Registered state
  state_e           state_q,     state_d;
  logic [KS_AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [KS_AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [KS_AW:0]   count_q,     count_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic [LEN_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q,      done_d;
  logic             busy_q,      busy_d;
  logic             ks_ready_q,  ks_ready_d;
  logic [7:0]       ks_mem_q [KS_DEPTH];

  // Combinational handshake terms
  logic       push_s;
  logic       in_hs_s;
  logic       out_take_s;
  logic       out_slot_free_s;
  logic       in_ready_s;
  logic [7:0] fifo_head_s;

  // Handshake qualification; in_ready follows out_ready combinationally so a
  // draining output slot can be refilled in the same cycle (full throughput)
  always_comb begin
    push_s          = ks_valid && ks_ready_q;
    out_slot_free_s = !out_valid_q || out_ready;
    out_take_s      = out_valid_q && out_ready;
    fifo_head_s     = ks_mem_q[rd_ptr_q];
    in_ready_s      = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready_s = (count_q != CNT_ZERO) && out_slot_free_s && (cnt_q < len_q);
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
    in_hs_s = in_valid && in_ready_s;
  end

  // FIFO pointer/occupancy next-state; a pop is exactly an input handshake
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (in_hs_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, in_hs_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // ks_ready is a flop derived from next occupancy, so a same-cycle pop
    // can only raise it from the following cycle onwards
    ks_ready_d = (count_d != FIFO_FULL);
  end

  // Output register: load on handshake, clear valid when taken without refill
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (in_hs_s) begin
      out_data_d  = in_data ^ fifo_head_s;
      out_valid_d = 1'b1;
    end else if (out_take_s) begin
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
    end else begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
    end
  end

  // Message FSM next-state: length latch, byte counter and done generation
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (msg_len != LEN_ZERO) begin
            len_d   = msg_len;
            cnt_d   = LEN_ZERO;
            state_d = ST_RUN;
          end else begin
            // Empty message completes immediately
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_hs_s) begin
          cnt_d = cnt_q + LEN_ONE;
          // cnt_q < len_q holds here, so the increment cannot wrap
          if ((cnt_q + LEN_ONE) == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Only the final byte can be in the output slot here
        if (out_take_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control/status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= PTR_ZERO;
      wr_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      len_q       <= LEN_ZERO;
      cnt_q       <= LEN_ZERO;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ks_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ks_ready_q  <= ks_ready_d;
    end
  end

  // Keystream storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      ks_mem_q[wr_ptr_q] <= ks_data;
    end
  end

  assign ks_ready  = ks_ready_q;
  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  rc4_xor_stage_chk #(
    .KS_DEPTH (KS_DEPTH),
    .KS_AW    (KS_AW)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .count     (count_q),
    .ks_ready  (ks_ready_q),
    .in_ready  (in_ready_s),
    .out_valid (out_valid_q),
    .out_ready (out_ready),
    .out_data  (out_data_q),
    .busy      (busy_q),
    .done      (done_q)
  );

endmodule

// -----------------------------------------------------------------------------
// rc4_xor_stage_chk
//
// Purpose:
//   Invariant checker for rc4_xor_stage. It has no outputs and contains only
//   properties, so synthesis tools ignore it.
//
// Ports:
//   clk, rst_n             clock and reset of the checked stage
//   count, ks_ready        FIFO occupancy and its ready flag
//   in_ready               input acceptance
//   out_valid/ready/data   output handshake
//   busy, done             status outputs
// -----------------------------------------------------------------------------
module rc4_xor_stage_chk #(
  parameter int KS_DEPTH = 8,
  parameter int KS_AW    = 3
) (
  input logic           clk,
  input logic           rst_n,
  input logic [KS_AW:0] count,
  input logic           ks_ready,
  input logic           in_ready,
  input logic           out_valid,
  input logic           out_ready,
  input logic [7:0]     out_data,
  input logic           busy,
  input logic           done
);

  localparam logic [KS_AW:0] FIFO_FULL = (KS_AW+1)'(KS_DEPTH);

  // Occupancy never exceeds the FIFO depth
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= FIFO_FULL);

  // ks_ready mirrors registered occupancy
  a_ks_ready: assert property (@(posedge clk) disable iff (!rst_n)
    ks_ready == (count != FIFO_FULL));

  // No data byte is accepted without keystream to pair it with
  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready |-> (count != {(KS_AW+1){1'b0}}));

  // A stalled output holds its data
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  // done is only raised once the stage has returned to idle
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

endmodule

// File: tb/tb_rc4_xor_stage.sv
// -----------------------------------------------------------------------------
// tb_rc4_xor_stage
//
// Bench for rc4_xor_stage. A transaction-level model tracks three things: the
// keystream queue, the single pending output byte and the message progress.
// Each cycle the model predicts every DUT output. Directed scenarios compare
// the collected output bytes against hand-computed XOR results. A randomized
// phase mixes keystream, data and sink stalls across many messages.
// -----------------------------------------------------------------------------
module tb_rc4_xor_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] msg_len;
  logic [7:0]  ks_data;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  rc4_xor_stage #(.KS_DEPTH(8), .KS_AW(3), .LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .msg_len   (msg_len),
    .ks_data   (ks_data),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] ksq[$];     // keystream held by the stage
  logic [7:0] ks_src[$];  // keystream waiting at the source
  logic [7:0] src_q[$];   // data bytes waiting at the source
  logic [7:0] got_q[$];   // bytes the sink has taken from the DUT
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_busy, m_drain, m_done;
  int         m_len, m_taken;
  int         done_cnt;
  int         cyc;
  int         or_mode;    // 0: sink always ready, 1: 1,0,0 pattern, 2: random
  bit         rnd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ksq.delete();
    m_ov    = 1'b0;
    m_od    = 8'h00;
    m_busy  = 1'b0;
    m_drain = 1'b0;
    m_done  = 1'b0;
    m_len   = 0;
    m_taken = 0;
  endtask

  // Compare DUT against the model before the edge, then advance the model
  task automatic tick();
    bit exp_ks_rdy, exp_in_rdy, hs, push, take, drain_pre;
    logic [7:0] k;
    #1;
    if (rst_n) begin
      exp_ks_rdy = (ksq.size() != 8);
      exp_in_rdy = m_busy && !m_drain && (ksq.size() != 0) &&
                   (!m_ov || out_ready) && (m_taken < m_len);
      check_eq("ks_ready",  ks_ready,  exp_ks_rdy);
      check_eq("in_ready",  in_ready,  exp_in_rdy);
      check_eq("out_valid", out_valid, m_ov);
      check_eq("out_data",  out_data,  m_od);
      check_eq("busy",      busy,      m_busy);
      check_eq("done",      done,      m_done);
      if (done) done_cnt++;
      hs        = in_valid && exp_in_rdy;
      push      = ks_valid && exp_ks_rdy;
      take      = m_ov && out_ready;
      drain_pre = m_drain;
      if (take) got_q.push_back(out_data);
      m_done = 1'b0;
      if (hs) begin
        k = ksq.pop_front();
        m_od = in_data ^ k;
        m_ov = 1'b1;
        m_taken++;
        if (m_taken == m_len) m_drain = 1'b1;
        if (src_q.size() != 0) void'(src_q.pop_front());
      end else if (take) begin
        m_ov = 1'b0;
      end
      if (drain_pre && take) begin
        m_done  = 1'b1;
        m_busy  = 1'b0;
        m_drain = 1'b0;
      end else if (!m_busy && start) begin
        if (msg_len == 16'd0) begin
          m_done = 1'b1;
        end else begin
          m_busy  = 1'b1;
          m_len   = int'(msg_len);
          m_taken = 0;
        end
      end
      if (push) begin
        ksq.push_back(ks_data);
        if (ks_src.size() != 0) void'(ks_src.pop_front());
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  // Present source queues and sink readiness for the coming cycle
  task automatic drive();
    ks_valid = (ks_src.size() != 0) && (!rnd || ($urandom_range(0, 3) != 0));
    ks_data  = (ks_src.size() != 0) ? ks_src[0] : 8'h00;
    in_valid = (src_q.size() != 0) && (!rnd || ($urandom_range(0, 3) != 0));
    in_data  = (src_q.size() != 0) ? src_q[0] : 8'($urandom_range(0, 255));
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 3) == 0);
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic step();
    drive();
    tick();
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ks_src.delete();
    src_q.delete();
    step();
    step();
    rst_n = 1'b1;
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input int len);
    start   = 1'b1;
    msg_len = 16'(len);
    step();
    start   = 1'b0;
  endtask

  // Run until the message has left the stage, bounded by max cycles
  task automatic finish_msg(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!busy && !out_valid && !m_busy && !m_ov) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("msg_timeout_busy", busy, 1'b0);
    step();  // observe the done pulse
  endtask

  task automatic check_got(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check_eq(tag, got_q[i], exp[i]);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int len;
    rst_n = 1'b0; start = 1'b0; msg_len = 16'd0; ks_data = 8'h00; ks_valid = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0; or_mode = 0; rnd = 1'b0; done_cnt = 0;
    model_reset();

    // Reset state
    do_reset();
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data",  out_data,  8'h00);
    check_eq("rst_ks_ready",  ks_ready,  1'b1);
    check_eq("rst_in_ready",  in_ready,  1'b0);
    check_eq("rst_busy",      busy,      1'b0);

    // 1: basic message, sink always ready
    ks_src = '{8'hEB, 8'h9F, 8'h77, 8'h81};
    repeat (5) step();
    src_q = '{8'h50, 8'h6C, 8'h61, 8'h69};
    pulse_start(4);
    finish_msg(40);
    check_got("t1_out", '{8'hBB, 8'hF3, 8'h16, 8'hE8});
    check_eq("t1_done_cnt", done_cnt, 1);

    // 2: same traffic with a stalling sink
    do_reset();
    or_mode = 1;
    ks_src = '{8'hEB, 8'h9F, 8'h77, 8'h81};
    repeat (5) step();
    src_q = '{8'h50, 8'h6C, 8'h61, 8'h69};
    pulse_start(4);
    finish_msg(60);
    check_got("t2_out", '{8'hBB, 8'hF3, 8'h16, 8'hE8});
    check_eq("t2_done_cnt", done_cnt, 1);
    or_mode = 0;

    // 3: overfill the FIFO, then free one slot
    do_reset();
    for (int i = 0; i < 9; i++) ks_src.push_back(8'(8'h10 + i));
    repeat (12) step();
    check_eq("t3_full_ks_ready", ks_ready, 1'b0);
    check_eq("t3_src_left", ks_src.size(), 1);
    src_q = '{8'h00};
    pulse_start(1);
    finish_msg(20);
    check_got("t3_out", '{8'h10});
    repeat (2) step();
    check_eq("t3_src_drained", ks_src.size(), 0);

    // 4: zero-length message leaves the FIFO alone
    do_reset();
    ks_src = '{8'h11, 8'h22};
    repeat (3) step();
    pulse_start(0);
    step();
    step();
    check_eq("t4_done_cnt", done_cnt, 1);
    check_eq("t4_busy", busy, 1'b0);
    src_q = '{8'hA0, 8'hB0};
    pulse_start(2);
    finish_msg(20);
    check_got("t4_out", '{8'hB1, 8'h92});

    // 5: reset in the middle of a message
    do_reset();
    for (int i = 0; i < 6; i++) ks_src.push_back(8'($urandom_range(0, 255)));
    repeat (7) step();
    for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom_range(0, 255)));
    pulse_start(6);
    for (int i = 0; i < 30 && m_taken < 2; i++) step();
    check_eq("t5_taken_two", m_taken, 2);
    src_q.delete();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("t5_out_valid", out_valid, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_ks_ready", ks_ready, 1'b1);
    check_eq("t5_in_ready", in_ready, 1'b0);
    got_q.delete();
    ks_src = '{8'hC3, 8'h5A, 8'h7E};
    repeat (4) step();
    src_q = '{8'h01, 8'h02, 8'h03};
    pulse_start(3);
    finish_msg(30);
    check_got("t5_out", '{8'hC2, 8'h58, 8'h7D});

    // 6: start while busy is ignored
    do_reset();
    for (int i = 0; i < 5; i++) ks_src.push_back(8'($urandom_range(0, 255)));
    repeat (6) step();
    for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom_range(0, 255)));
    or_mode = 1;
    pulse_start(3);
    step();
    pulse_start(5);
    finish_msg(40);
    check_eq("t6_done_cnt", done_cnt, 1);
    check_eq("t6_bytes", got_q.size(), 3);
    check_eq("t6_src_left", src_q.size(), 2);
    or_mode = 0;

    // Randomized messages with random keystream, data and sink stalls
    do_reset();
    rnd = 1'b1;
    or_mode = 2;
    for (int m = 0; m < 40; m++) begin
      len = $urandom_range(0, 12);
      for (int i = 0; i < len + $urandom_range(0, 3); i++)
        ks_src.push_back(8'($urandom_range(0, 255)));
      src_q.delete();
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) step();
      done_cnt = 0;
      pulse_start(len);
      finish_msg(400);
      check_eq("rnd_done_cnt", done_cnt, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
